match_ctrl: RTL and testbench
=============================

Name: match_ctrl

Overview:
- Round/match sequencer directly downstream of the bomb stage; consumes its 2-bit game_state (round result) each clk.
- Scores a first-to-WIN_ROUNDS match, holds the round result on screen for a fixed number of 1 Hz ticks, then issues a one-cycle round restart pulse to the initialize/chara_control/bomb stages.
- Drives a freeze flag that gates player input, plus score/round counters for sevenSeg and VGA.

Parameters:
- WIN_ROUNDS, 3, rounds needed to win the match (1..15).
- HOLD_TICKS, 3, tick pulses spent in ROUND_OVER before advancing (1..15).
- MAX_ROUNDS, 15, hard cap on rounds played, which bounds endless draws (1..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-clk-wide pulse at 1 Hz (bomb_clk rising edge, already synchronised).
- start  in  1  one-clk-wide pulse from a debounced button.
- game_state  in  2  00 playing, 01 A won round, 10 B won round, 11 draw.
- round_rst  out  1  one-clk pulse: reinitialise arena, bombs, health and positions.
- freeze  out  1  high means chara_control ignores moves and bomb drops.
- scoreA  out  4  rounds won by A.
- scoreB  out  4  rounds won by B.
- round_num  out  4  current round, 1-based; 0 before the first start.
- match_state  out  2  00 IDLE, 01 PLAY, 10 ROUND_OVER, 11 MATCH_OVER.
- match_winner  out  2  00 none, 01 A, 10 B, 11 draw; valid in MATCH_OVER, otherwise 00.

Behaviour:
- All outputs registered. On rst (any state, mid-round included), next edge gives:
  - state IDLE, scoreA=scoreB=0, round_num=0, round_rst=0, freeze=1, match_winner=00;
  - guard=0, hold=0.
- IDLE:
  - freeze=1.
  - start → round_rst=1 for exactly the next cycle, round_num=1, enter PLAY, guard loaded with 2.
- PLAY:
  - freeze=0.
  - guard decrements each clk while nonzero; game_state is ignored while guard!=0, which masks stale results during the restart.
  - With guard==0, the first cycle game_state!=00 latches the result:
    - 01 → scoreA+1;
    - 10 → scoreB+1;
    - 11 → no score change.
  - Latching a result enters ROUND_OVER with hold=0 and freeze=1 from the next cycle.
  - start is ignored.
- ROUND_OVER:
  - freeze=1.
  - Each tick increments hold. A tick in the same cycle as entry is not counted.
  - When hold reaches HOLD_TICKS (the cycle of the HOLD_TICKS-th tick), the decision is, in priority order:
    1. scoreA==WIN_ROUNDS → MATCH_OVER, winner 01.
    2. scoreB==WIN_ROUNDS → MATCH_OVER, winner 10.
    3. round_num==MAX_ROUNDS → MATCH_OVER, winner decided by scores: higher score wins, equal → 11.
    4. Otherwise → round_rst pulse, round_num+1, PLAY, guard=2.
  - start and game_state are ignored.
- MATCH_OVER:
  - freeze=1; outputs hold.
  - start → scores cleared, round_num=1, match_winner=00, round_rst pulse, PLAY, guard=2.
- round_rst:
  - Never high for two consecutive cycles.
  - High only in the cycle after a start (IDLE/MATCH_OVER) or after a ROUND_OVER advance.
- Widths:
  - Scores cannot exceed WIN_ROUNDS.
  - round_num never exceeds MAX_ROUNDS; no wrap.
- Simultaneous events:
  - start + tick in IDLE: the start is taken and the tick is ignored.
  - rst overrides everything.

Test Plan:
1. rst high 2 cycles, then low → state 00, freeze=1, all counters 0, round_rst=0. Then a start pulse → round_rst=1 for 1 cycle, round_num=1, state 01, freeze=0.
2. In PLAY, drive game_state=01 in the cycle right after round_rst → ignored (guard). Hold game_state=01 after the guard expires → scoreA=1, state 10, freeze=1. After 3 ticks → round_rst pulse, round_num=2, state 01.
3. Game_state sequence 01, 10, 01, 01, with game_state returned to 00 after each restart → scores A=3, B=1. After the 4th round's 3 ticks → state 11, match_winner=01, no round_rst; start → scores 0/0, round_num=1, round_rst pulse.
4. Fifteen consecutive draws (11) → scores stay 0/0, round_num climbs 1..15. After the 15th hold → MATCH_OVER, match_winner=11.
5. Assert rst during ROUND_OVER with hold=2 → next cycle state IDLE, scores 0, round_num=0, no round_rst pulse. Start pulses during PLAY and ROUND_OVER cause no change.
6. A tick in the same cycle as the result latch is not counted: ROUND_OVER lasts exactly 3 further ticks, and round_rst is checked as a single-cycle pulse.

Source files
------------

// File: rtl/match_ctrl.sv
// Match sequencer: scores rounds reported by the bomb stage, holds each result
// for HOLD_TICKS one-second ticks, then restarts the round or ends the match.
module match_ctrl #(
   parameter int WIN_ROUNDS = 3,
   parameter int HOLD_TICKS = 3,
   parameter int MAX_ROUNDS = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       start,
   input  logic [1:0] game_state,
   output logic       round_rst,
   output logic       freeze,
   output logic [3:0] scoreA,
   output logic [3:0] scoreB,
   output logic [3:0] round_num,
   output logic [1:0] match_state,
   output logic [1:0] match_winner
);

   typedef enum logic [1:0] {
      IDLE       = 2'b00,
      PLAY       = 2'b01,
      ROUND_OVER = 2'b10,
      MATCH_OVER = 2'b11
   } state_t;

   localparam logic [3:0] WIN_N  = 4'(WIN_ROUNDS);
   localparam logic [3:0] HOLD_N = 4'(HOLD_TICKS);
   localparam logic [3:0] MAX_N  = 4'(MAX_ROUNDS);

   state_t     state;
   logic [1:0] guard;
   logic [3:0] hold;
   logic [3:0] hold_next;

   assign hold_next   = hold + 4'd1;
   assign match_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         scoreA       <= 4'd0;
         scoreB       <= 4'd0;
         round_num    <= 4'd0;
         round_rst    <= 1'b0;
         freeze       <= 1'b1;
         match_winner <= 2'b00;
         guard        <= 2'd0;
         hold         <= 4'd0;
      end else begin
         round_rst <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  round_rst <= 1'b1;
                  round_num <= 4'd1;
                  guard     <= 2'd2;
                  freeze    <= 1'b0;
                  state     <= PLAY;
               end
            end

            PLAY: begin
               // The guard window hides results left over from the previous
               // round while the downstream stages are being reinitialised.
               if (guard != 2'd0) begin
                  guard <= guard - 2'd1;
               end else if (game_state != 2'b00) begin
                  if (game_state == 2'b01 && scoreA != WIN_N) scoreA <= scoreA + 4'd1;
                  if (game_state == 2'b10 && scoreB != WIN_N) scoreB <= scoreB + 4'd1;
                  hold   <= 4'd0;
                  freeze <= 1'b1;
                  state  <= ROUND_OVER;
               end
            end

            ROUND_OVER: begin
               if (tick) begin
                  hold <= hold_next;
                  if (hold_next == HOLD_N) begin
                     if (scoreA == WIN_N) begin
                        match_winner <= 2'b01;
                        state        <= MATCH_OVER;
                     end else if (scoreB == WIN_N) begin
                        match_winner <= 2'b10;
                        state        <= MATCH_OVER;
                     end else if (round_num == MAX_N) begin
                        if (scoreA > scoreB)      match_winner <= 2'b01;
                        else if (scoreB > scoreA) match_winner <= 2'b10;
                        else                      match_winner <= 2'b11;
                        state <= MATCH_OVER;
                     end else begin
                        round_rst <= 1'b1;
                        round_num <= round_num + 4'd1;
                        guard     <= 2'd2;
                        hold      <= 4'd0;
                        freeze    <= 1'b0;
                        state     <= PLAY;
                     end
                  end
               end
            end

            MATCH_OVER: begin
               if (start) begin
                  scoreA       <= 4'd0;
                  scoreB       <= 4'd0;
                  round_num    <= 4'd1;
                  match_winner <= 2'b00;
                  round_rst    <= 1'b1;
                  guard        <= 2'd2;
                  hold         <= 4'd0;
                  freeze       <= 1'b0;
                  state        <= PLAY;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_match_ctrl.sv
// Bench for match_ctrl: directed match scenarios followed by random traffic,
// every cycle compared against a round/phase level model of the match rules.
module tb_match_ctrl;

   localparam int WIN  = 3;
   localparam int HOLD = 3;
   localparam int MAXR = 15;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick = 1'b0;
   logic       start = 1'b0;
   logic [1:0] game_state = 2'b00;
   logic       round_rst;
   logic       freeze;
   logic [3:0] scoreA;
   logic [3:0] scoreB;
   logic [3:0] round_num;
   logic [1:0] match_state;
   logic [1:0] match_winner;

   int n_vec = 0;
   int n_err = 0;

   // model: phase 0 idle, 1 playing, 2 showing result, 3 match finished
   int   m_phase = 0;
   int   m_sa = 0;
   int   m_sb = 0;
   int   m_round = 0;
   int   m_since = 0;
   int   m_ticks = 0;
   int   m_win = 0;
   logic m_rr = 1'b0;
   logic prev_rr = 1'b0;

   match_ctrl #(.WIN_ROUNDS(WIN), .HOLD_TICKS(HOLD), .MAX_ROUNDS(MAXR)) dut (
      .clk(clk),
      .rst(rst),
      .tick(tick),
      .start(start),
      .game_state(game_state),
      .round_rst(round_rst),
      .freeze(freeze),
      .scoreA(scoreA),
      .scoreB(scoreB),
      .round_num(round_num),
      .match_state(match_state),
      .match_winner(match_winner)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic new_round();
      m_rr    = 1'b1;
      m_phase = 1;
      m_since = 0;
      m_ticks = 0;
   endtask

   task automatic model_edge(input logic r, input logic s, input logic t, input logic [1:0] gs);
      m_rr = 1'b0;
      if (r) begin
         m_phase = 0; m_sa = 0; m_sb = 0; m_round = 0;
         m_since = 0; m_ticks = 0; m_win = 0;
      end else if (m_phase == 0 || m_phase == 3) begin
         if (s) begin
            m_sa = 0; m_sb = 0; m_round = 1; m_win = 0;
            new_round();
         end
      end else if (m_phase == 1) begin
         if (m_since >= 2 && gs != 2'b00) begin
            if (gs == 2'b01) m_sa++;
            if (gs == 2'b10) m_sb++;
            m_phase = 2;
            m_ticks = 0;
         end
         m_since++;
      end else if (t) begin
         m_ticks++;
         if (m_ticks == HOLD) begin
            if (m_sa == WIN) begin
               m_phase = 3; m_win = 1;
            end else if (m_sb == WIN) begin
               m_phase = 3; m_win = 2;
            end else if (m_round == MAXR) begin
               m_phase = 3;
               m_win = (m_sa > m_sb) ? 1 : (m_sb > m_sa) ? 2 : 3;
            end else begin
               m_round++;
               new_round();
            end
         end
      end
   endtask

   task automatic cyc(input logic r, input logic s, input logic t, input logic [1:0] gs);
      rst = r; start = s; tick = t; game_state = gs;
      @(posedge clk);
      model_edge(r, s, t, gs);
      #1;
      check("match_state", 8'(match_state), 8'(m_phase));
      check("scoreA", 8'(scoreA), 8'(m_sa));
      check("scoreB", 8'(scoreB), 8'(m_sb));
      check("round_num", 8'(round_num), 8'(m_round));
      check("round_rst", 8'(round_rst), 8'(m_rr));
      check("freeze", 8'(freeze), 8'(m_phase != 1));
      check("match_winner", 8'(match_winner), 8'(m_win));
      check("round_rst_double", 8'(prev_rr & round_rst), 8'd0);
      prev_rr = round_rst;
   endtask

   // Stale result during the guard window, then the real latch, then the hold ticks.
   task automatic play_round(input logic [1:0] res, input logic poke, input logic tick_at_latch);
      cyc(1'b0, poke, 1'b0, res);
      cyc(1'b0, 1'b0, 1'b0, res);
      cyc(1'b0, 1'b0, tick_at_latch, res);
      for (int i = 0; i < HOLD; i++) begin
         cyc(1'b0, poke, 1'b0, 2'($urandom_range(0, 3)));
         cyc(1'b0, 1'b0, 1'b1, 2'b00);
      end
   endtask

   initial begin
      // reset and first start, with a tick coinciding with the start
      cyc(1'b1, 1'b0, 1'b0, 2'b00);
      cyc(1'b1, 1'b0, 1'b0, 2'b00);
      cyc(1'b0, 1'b0, 1'b1, 2'b00);
      cyc(1'b0, 1'b0, 1'b0, 2'b11);
      cyc(1'b0, 1'b1, 1'b1, 2'b00);

      // A wins, B wins, A, A -> match to A at 3-1
      play_round(2'b01, 1'b0, 1'b0);
      play_round(2'b10, 1'b0, 1'b0);
      play_round(2'b01, 1'b0, 1'b0);
      play_round(2'b01, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 2'b01);
      cyc(1'b0, 1'b0, 1'b0, 2'b00);

      // restart match, fifteen draws -> match drawn
      cyc(1'b0, 1'b1, 1'b0, 2'b00);
      for (int i = 0; i < MAXR; i++) play_round(2'b11, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 2'b00);

      // reset while showing a result with two ticks counted; stray starts ignored
      cyc(1'b0, 1'b1, 1'b0, 2'b00);
      cyc(1'b0, 1'b1, 1'b0, 2'b10);
      cyc(1'b0, 1'b1, 1'b0, 2'b10);
      cyc(1'b0, 1'b1, 1'b0, 2'b10);
      cyc(1'b0, 1'b1, 1'b1, 2'b00);
      cyc(1'b0, 1'b0, 1'b1, 2'b00);
      cyc(1'b1, 1'b0, 1'b0, 2'b00);
      cyc(1'b0, 1'b0, 1'b0, 2'b00);

      // tick on the latch cycle does not count toward the hold
      cyc(1'b0, 1'b1, 1'b0, 2'b00);
      play_round(2'b10, 1'b1, 1'b1);
      play_round(2'b10, 1'b1, 1'b1);
      play_round(2'b10, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 2'b00);

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         logic       r;
         logic       s;
         logic       t;
         logic [1:0] gs;
         r  = ($urandom_range(0, 299) == 0);
         s  = ($urandom_range(0, 24) == 0);
         t  = ($urandom_range(0, 3) == 0);
         gs = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
         cyc(r, s, t, gs);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
